// File: rtl/obc_check_pkg.sv
// Shared constants for the OBC challenge/response checker: FSM encoding,
// question generator seed/taps, answer width and the generator step.
package obc_check_pkg;

  localparam int ANS_W = 4;
  localparam int ST_W  = 3;

  // FSM state encoding; also the value seen on the state_dbg port.
  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_ISSUE    = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_ANS = 3'd2;
  localparam logic [ST_W-1:0] ST_EVAL     = 3'd3;
  localparam logic [ST_W-1:0] ST_RETRY    = 3'd4;
  localparam logic [ST_W-1:0] ST_SHUTDOWN = 3'd5;

  // Question generator: default seed and feedback taps (bits 3 and 2).
  localparam logic [ANS_W-1:0] LFSR_SEED_DEF = 4'b0001;
  localparam logic [ANS_W-1:0] LFSR_TAPS     = 4'b1100;

  // One step of the question generator: shift left, feedback into bit 0.
  function automatic logic [ANS_W-1:0] lfsr_next(input logic [ANS_W-1:0] q);
    return {q[ANS_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/obc_answer_calc.sv
// Expected OBC answer for a given challenge value (pure combinational).
module obc_answer_calc
  import obc_check_pkg::*;
(
  input  logic [ANS_W-1:0] q,
  output logic [ANS_W-1:0] a
);

  // Bit 0 is the inverted LSB; higher bits are XORs of adjacent question bits.
  assign a = {q[2] ^ q[3], q[1] ^ q[2], q[0] ^ q[1], ~q[0]};

endmodule

// File: rtl/obc_challenge_ctrl.sv
// Challenge/response supervisor for OBC1: issues LFSR questions, checks the
// answers over a round, retries once after an OBC1 reset and hands control to
// OBC2 (override) if the retry round also fails.
//
// Handshake: q_valid is raised in ISSUE and held, with question stable, until
// the cycle q_ready is seen high; that cycle is the transfer. ans_valid is a
// single-cycle strobe with no back-pressure, honoured only while waiting.
module obc_challenge_ctrl
  import obc_check_pkg::*;
#(
  parameter int               ROUND_LEN   = 10,
  parameter int               TIMEOUT_CYC = 255,
  parameter logic [ANS_W-1:0] LFSR_SEED   = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [ANS_W-1:0] question,
  input  logic             ans_valid,
  input  logic [ANS_W-1:0] answer_obc,
  output logic             busy,
  output logic             check_ok,
  output logic             override,
  output logic             obc1_reset,
  output logic [3:0]       fail_cnt,
  output logic [ST_W-1:0]  state_dbg
);

  localparam logic [3:0] ROUND_LEN_C = 4'(ROUND_LEN);
  localparam logic [7:0] TMO_LOAD    = 8'(TIMEOUT_CYC);

  logic [ST_W-1:0]  state_q,    state_n;
  logic [ANS_W-1:0] lfsr_q,     lfsr_n;
  logic [ANS_W-1:0] q_hold_q,   q_hold_n;
  logic [ANS_W-1:0] ans_q,      ans_n;
  logic [3:0]       qcnt_q,     qcnt_n;
  logic [3:0]       fail_q,     fail_n;
  logic [7:0]       tmo_q,      tmo_n;
  logic             tmo_fail_q, tmo_fail_n;
  logic             retry_q,    retry_n;
  logic             check_ok_q, check_ok_n;

  logic [ANS_W-1:0] exp_ans;
  logic             q_wrong;
  logic [3:0]       fail_sum;

  // Expected answer for the question that was accepted by OBC1.
  obc_answer_calc u_answer_calc (
    .q (q_hold_q),
    .a (exp_ans)
  );

  // Verdict of the question under evaluation and the saturating fail count.
  always_comb begin
    q_wrong  = tmo_fail_q || (ans_q != exp_ans);
    fail_sum = (q_wrong && (fail_q != 4'd15)) ? fail_q + 4'd1 : fail_q;
  end

  // Next-state and next-register values for the whole controller.
  always_comb begin
    state_n    = state_q;
    lfsr_n     = lfsr_q;
    q_hold_n   = q_hold_q;
    ans_n      = ans_q;
    qcnt_n     = qcnt_q;
    fail_n     = fail_q;
    tmo_n      = tmo_q;
    tmo_fail_n = tmo_fail_q;
    retry_n    = retry_q;
    check_ok_n = check_ok_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_ISSUE;
          fail_n  = 4'd0;
          qcnt_n  = 4'd0;
        end
      end
      ST_ISSUE: begin
        if (q_ready) begin
          state_n    = ST_WAIT_ANS;
          tmo_n      = TMO_LOAD;
          tmo_fail_n = 1'b0;
          q_hold_n   = lfsr_q;
          lfsr_n     = lfsr_next(lfsr_q);
        end
      end
      ST_WAIT_ANS: begin
        // An answer arriving in the last allowed cycle still wins over timeout.
        if (ans_valid) begin
          ans_n   = answer_obc;
          state_n = ST_EVAL;
        end else begin
          tmo_n = tmo_q - 8'd1;
          if (tmo_q == 8'd1) begin
            tmo_fail_n = 1'b1;
            state_n    = ST_EVAL;
          end
        end
      end
      ST_EVAL: begin
        fail_n = fail_sum;
        qcnt_n = qcnt_q + 4'd1;
        if ((qcnt_q + 4'd1) < ROUND_LEN_C) begin
          state_n = ST_ISSUE;
        end else if (fail_sum == 4'd0) begin
          state_n    = ST_IDLE;
          check_ok_n = 1'b1;
          retry_n    = 1'b0;
        end else if (!retry_q) begin
          state_n    = ST_RETRY;
          check_ok_n = 1'b0;
        end else begin
          state_n    = ST_SHUTDOWN;
          check_ok_n = 1'b0;
        end
      end
      ST_RETRY: begin
        retry_n = 1'b1;
        fail_n  = 4'd0;
        qcnt_n  = 4'd0;
        state_n = ST_ISSUE;
      end
      ST_SHUTDOWN: begin
        state_n = ST_SHUTDOWN;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // All controller registers; reset aborts any round in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LFSR_SEED;
      q_hold_q   <= LFSR_SEED;
      ans_q      <= '0;
      qcnt_q     <= 4'd0;
      fail_q     <= 4'd0;
      tmo_q      <= 8'd0;
      tmo_fail_q <= 1'b0;
      retry_q    <= 1'b0;
      check_ok_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      lfsr_q     <= lfsr_n;
      q_hold_q   <= q_hold_n;
      ans_q      <= ans_n;
      qcnt_q     <= qcnt_n;
      fail_q     <= fail_n;
      tmo_q      <= tmo_n;
      tmo_fail_q <= tmo_fail_n;
      retry_q    <= retry_n;
      check_ok_q <= check_ok_n;
    end
  end

  // Outputs decoded from state so they follow an async reset immediately.
  always_comb begin
    q_valid    = (state_q == ST_ISSUE);
    busy       = (state_q != ST_IDLE) && (state_q != ST_SHUTDOWN);
    override   = (state_q == ST_SHUTDOWN);
    obc1_reset = (state_q == ST_RETRY);
    question   = lfsr_q;
    fail_cnt   = fail_q;
    check_ok   = check_ok_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_obc_challenge_ctrl.sv
// Self-checking bench for obc_challenge_ctrl: randomized timing around a
// behavioural model of the question sequence, answers and round verdicts.
module tb_obc_challenge_ctrl;
  import obc_check_pkg::*;

  localparam int RL  = 10;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       q_valid;
  logic       q_ready = 1'b0;
  logic [3:0] question;
  logic       ans_valid = 1'b0;
  logic [3:0] answer_obc = 4'd0;
  logic       busy, check_ok, override, obc1_reset;
  logic [3:0] fail_cnt;
  logic [2:0] state_dbg;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic [3:0] m_lfsr = 4'b0001;
  int         m_fail = 0;
  bit         m_retry = 1'b0;
  logic [3:0] exp_q[$];
  int         round_modes[RL];
  int         stall_first = -1;

  obc_challenge_ctrl #(.ROUND_LEN(RL), .TIMEOUT_CYC(TMO), .LFSR_SEED(4'b0001)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .question   (question),
    .ans_valid  (ans_valid),
    .answer_obc (answer_obc),
    .busy       (busy),
    .check_ok   (check_ok),
    .override   (override),
    .obc1_reset (obc1_reset),
    .fail_cnt   (fail_cnt),
    .state_dbg  (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Generator step written arithmetically: double mod 16, plus bit3 xor bit2.
  function automatic logic [3:0] m_next(input logic [3:0] q);
    int v;
    v = int'(q);
    return 4'(((v * 2) % 16) + (((v / 8) % 2 + (v / 4) % 2) % 2));
  endfunction

  function automatic logic [3:0] m_answer(input logic [3:0] q);
    int v, a0, a1, a2, a3;
    v  = int'(q);
    a0 = 1 - (v % 2);
    a1 = ((v % 2) + (v / 2) % 2) % 2;
    a2 = ((v / 2) % 2 + (v / 4) % 2) % 2;
    a3 = ((v / 4) % 2 + (v / 8) % 2) % 2;
    return 4'(a0 + 2 * a1 + 4 * a2 + 8 * a3);
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0; start = 1'b0; q_ready = 1'b0; ans_valid = 1'b0; answer_obc = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rst_q_valid: got %b want 0", q_valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (check_ok !== 1'b0) begin errors++; $display("FAIL rst_check_ok: got %b want 0", check_ok); end
    vectors++; if (override !== 1'b0) begin errors++; $display("FAIL rst_override: got %b want 0", override); end
    vectors++; if (obc1_reset !== 1'b0) begin errors++; $display("FAIL rst_obc1_reset: got %b want 0", obc1_reset); end
    vectors++; if (fail_cnt !== 4'd0) begin errors++; $display("FAIL rst_fail_cnt: got %0d want 0", fail_cnt); end
    vectors++; if (question !== 4'b0001) begin errors++; $display("FAIL rst_question: got %b want 0001", question); end
    reset_n = 1'b1;
    m_lfsr = 4'b0001; m_fail = 0; m_retry = 1'b0; exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_fail = 0;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    vectors++; if (fail_cnt !== 4'd0) begin errors++; $display("FAIL start_fail_cnt: got %0d want 0", fail_cnt); end
  endtask

  // mode: 0 correct, 1 wrong, 2 no answer, 3 correct on last allowed cycle, 4 answer 0000
  task automatic play_question(input int mode, input int rdy_req);
    int n, rdy_dly, ans_dly;
    logic [3:0] qv, exp_ans, given;
    bit bad;
    rdy_dly = (rdy_req >= 0) ? rdy_req : $urandom_range(0, 2);
    ans_dly = (mode == 3) ? TMO - 1 : $urandom_range(0, TMO - 2);
    n = 0;
    while (q_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    vectors++;
    if (q_valid !== 1'b1) begin errors++; $display("FAIL q_valid_wait: got %b want 1", q_valid); return; end
    qv = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
    vectors++; if (question !== qv) begin errors++; $display("FAIL question: got %b want %b", question, qv); end
    // Hold off ready; stray answer strobes here must be ignored.
    for (int i = 0; i < rdy_dly; i++) begin
      ans_valid = 1'($urandom_range(0, 1));
      answer_obc = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      vectors++;
      if (q_valid !== 1'b1 || question !== qv || state_dbg !== ST_ISSUE) begin
        errors++; $display("FAIL stall_hold: q_valid=%b question=%b state=%0d want 1/%b/%0d", q_valid, question, state_dbg, qv, ST_ISSUE);
      end
    end
    ans_valid = 1'b0;
    q_ready = 1'b1;
    @(posedge clk);
    #1;
    q_ready = 1'b0;
    exp_ans = m_answer(qv);
    given = exp_ans;
    if (mode == 2) begin
      repeat (TMO - 1) @(posedge clk);
      #1;
      vectors++; if (state_dbg !== ST_WAIT_ANS) begin errors++; $display("FAIL tmo_wait: state %0d want %0d", state_dbg, ST_WAIT_ANS); end
      @(posedge clk);
      #1;
    end else begin
      for (int i = 0; i < ans_dly; i++) begin @(posedge clk); #1; end
      if (mode == 1) given = exp_ans ^ 4'($urandom_range(1, 15));
      if (mode == 4) given = 4'b0000;
      ans_valid = 1'b1;
      answer_obc = given;
      @(posedge clk);
      #1;
      ans_valid = 1'b0;
      answer_obc = 4'($urandom_range(0, 15));
    end
    vectors++; if (state_dbg !== ST_EVAL) begin errors++; $display("FAIL eval_entry: state %0d want %0d", state_dbg, ST_EVAL); end
    bad = (mode == 2) || (given != exp_ans);
    if (bad && m_fail < 15) m_fail++;
    @(posedge clk);
    #1;
    vectors++; if (fail_cnt !== 4'(m_fail)) begin errors++; $display("FAIL fail_cnt: got %0d want %0d", fail_cnt, m_fail); end
  endtask

  // verdict: 0 pass, 1 retry, 2 shutdown
  task automatic play_round(output int verdict);
    exp_q.delete();
    m_fail = 0;
    for (int i = 0; i < RL; i++) begin exp_q.push_back(m_lfsr); m_lfsr = m_next(m_lfsr); end
    for (int i = 0; i < RL; i++) play_question(round_modes[i], (i == 0) ? stall_first : -1);
    if (m_fail == 0) begin
      verdict = 0; m_retry = 1'b0;
      vectors++;
      if (check_ok !== 1'b1 || busy !== 1'b0 || override !== 1'b0 || obc1_reset !== 1'b0) begin
        errors++; $display("FAIL pass_verdict: ok=%b busy=%b ovr=%b rst=%b want 1/0/0/0", check_ok, busy, override, obc1_reset);
      end
    end else if (!m_retry) begin
      verdict = 1; m_retry = 1'b1;
      vectors++;
      if (obc1_reset !== 1'b1 || busy !== 1'b1 || check_ok !== 1'b0 || override !== 1'b0) begin
        errors++; $display("FAIL retry_verdict: rst=%b busy=%b ok=%b ovr=%b want 1/1/0/0", obc1_reset, busy, check_ok, override);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (obc1_reset !== 1'b0 || fail_cnt !== 4'd0 || q_valid !== 1'b1) begin
        errors++; $display("FAIL retry_exit: rst=%b fail_cnt=%0d q_valid=%b want 0/0/1", obc1_reset, fail_cnt, q_valid);
      end
      m_fail = 0;
    end else begin
      verdict = 2;
      vectors++;
      if (override !== 1'b1 || busy !== 1'b0 || q_valid !== 1'b0 || check_ok !== 1'b0) begin
        errors++; $display("FAIL shutdown_verdict: ovr=%b busy=%b q_valid=%b ok=%b want 1/0/0/0", override, busy, q_valid, check_ok);
      end
    end
  endtask

  task automatic clear_modes();
    for (int i = 0; i < RL; i++) round_modes[i] = 0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_pass_round();
    int v;
    clear_modes();
    start_round();
    play_round(v);
    vectors++; if (v != 0) begin errors++; $display("FAIL pass_round: verdict %0d want 0", v); end
  endtask

  task automatic test_retry_recovers();
    int v;
    clear_modes();
    round_modes[2] = 4;
    start_round();
    play_round(v);
    if (v == 1) begin
      clear_modes();
      play_round(v);
      vectors++; if (override !== 1'b0) begin errors++; $display("FAIL retry_override: got %b want 0", override); end
    end
  endtask

  task automatic test_shutdown();
    int v;
    clear_modes();
    round_modes[0] = 1;
    start_round();
    play_round(v);
    if (v == 1) play_round(v);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (override !== 1'b1 || busy !== 1'b0 || q_valid !== 1'b0) begin
        errors++; $display("FAIL shutdown_sticky: ovr=%b busy=%b q_valid=%b want 1/0/0", override, busy, q_valid);
      end
    end
    start = 1'b0;
    apply_reset();
    vectors++; if (override !== 1'b0) begin errors++; $display("FAIL shutdown_clear: got %b want 0", override); end
  endtask

  task automatic test_timeout();
    int v;
    clear_modes();
    round_modes[0] = 2;
    round_modes[1] = 3;
    start_round();
    play_round(v);
    vectors++; if (v != 1) begin errors++; $display("FAIL timeout_round: verdict %0d want 1", v); end
    if (v == 1) begin
      for (int i = 0; i < RL; i++) round_modes[i] = 3;
      play_round(v);
    end
  endtask

  task automatic test_ready_stall();
    int v;
    clear_modes();
    stall_first = 20;
    start_round();
    play_round(v);
    stall_first = -1;
  endtask

  task automatic test_reset_mid_round();
    int v, n;
    clear_modes();
    start_round();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin exp_q.push_back(m_lfsr); m_lfsr = m_next(m_lfsr); end
    for (int i = 0; i < 4; i++) play_question(0, -1);
    n = 0;
    while (q_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    q_ready = 1'b1;
    @(posedge clk);
    #1;
    q_ready = 1'b0;
    vectors++; if (state_dbg !== ST_WAIT_ANS) begin errors++; $display("FAIL mid_wait: state %0d want %0d", state_dbg, ST_WAIT_ANS); end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (q_valid !== 1'b0 || busy !== 1'b0 || check_ok !== 1'b0 || override !== 1'b0 ||
        obc1_reset !== 1'b0 || fail_cnt !== 4'd0 || question !== 4'b0001) begin
      errors++; $display("FAIL mid_reset: qv=%b busy=%b ok=%b ovr=%b rst=%b fc=%0d q=%b want 0/0/0/0/0/0/0001",
                         q_valid, busy, check_ok, override, obc1_reset, fail_cnt, question);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_lfsr = 4'b0001; m_fail = 0; m_retry = 1'b0; exp_q.delete();
    @(posedge clk);
    #1;
    start_round();
    play_round(v);
  endtask

  task automatic test_random_rounds();
    int v;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < RL; i++) round_modes[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      start_round();
      play_round(v);
      if (v == 1) begin
        for (int i = 0; i < RL; i++) round_modes[i] = ($urandom_range(0, 7) == 0) ? 1 : 0;
        play_round(v);
      end
      if (v == 2) apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_pass_round();
    test_retry_recovers();
    test_shutdown();
    test_timeout();
    test_ready_stall();
    test_reset_mid_round();
    test_random_rounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
